store_sequence_checker: RTL and testbench
=========================================

Name: store_sequence_checker

Overview:
- Synthesisable self-check monitor for the pipelined core's data-memory write port.
- Generalises the single-store pass/fail test check to a programmable, ordered sequence of up to DEPTH expected stores, with per-entry data masks and a tolerated scratch-address window.
- Adds a cycle watchdog and a registered verdict with a failure code and the capture of the failing store.
- Sits beside top_pipeline, tapping MemWrite/DataAdr/WriteData; usable in simulation benches and in FPGA bring-up.

Parameters:
- XLEN, 32, width of address/data buses.
- DEPTH, 4, maximum expected-store entries (power of two, >=2).
- TO_W, 16, watchdog counter width.
- TIMEOUT, 1000, cycles after arm before FAIL_TIMEOUT; must be < 2**TO_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_write  in  1  store valid this cycle (MemWrite)
- data_adr  in  XLEN  store address (DataAdr)
- write_data  in  XLEN  store data (WriteData)
- cfg_we  in  1  write expected-table entry
- cfg_idx  in  $clog2(DEPTH)  entry index
- cfg_addr  in  XLEN  expected address
- cfg_data  in  XLEN  expected data
- cfg_mask  in  XLEN  data compare mask (1 = compare bit)
- cfg_num  in  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- ign_lo  in  XLEN  scratch window low bound, inclusive
- ign_hi  in  XLEN  scratch window high bound, inclusive; window empty if ign_lo > ign_hi
- arm  in  1  start-check pulse
- busy  out  1  state == RUN
- done  out  1  verdict valid (PASS or FAIL)
- pass  out  1  sequence matched
- fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout
- fail_addr  out  XLEN  address of failing store (0 on timeout)
- fail_data  out  XLEN  data of failing store (0 on timeout)
- store_cnt  out  16  stores seen since arm, saturating at 16'hFFFF
- exp_ptr  out  $clog2(DEPTH)+1  entries matched so far

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; table entries and num_latched cleared. Reset mid-RUN aborts with no verdict.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL are sticky until arm or reset.
- cfg_we is honoured in IDLE, PASS and FAIL. It is ignored in RUN. Writes with cfg_idx >= DEPTH cannot occur, because the width is exact.
- arm in IDLE/PASS/FAIL: cfg_num and the ign window are latched. The next state is RUN, with store_cnt, exp_ptr, watchdog, fail_* and pass/done cleared.
- arm with cfg_num == 0: go directly to PASS, with done=1 and pass=1 one cycle after arm.
- arm during RUN is ignored.
- RUN, per posedge with mem_write=1, using entry E = table[exp_ptr]; the first matching rule applies:
  1. data_adr == E.addr and (write_data & E.mask) == (E.data & E.mask): exp_ptr++. If the new exp_ptr == num_latched, go to PASS.
  2. data_adr == E.addr and data mismatch: FAIL code 2.
  3. ign_lo <= data_adr <= ign_hi (unsigned compare): ignore.
  4. Otherwise: FAIL code 1.
- store_cnt increments on every RUN store, including the deciding one.
- Only entry exp_ptr is eligible for a match. A later entry's address arriving early falls through to the window check or FAIL 1.
- Watchdog:
  - Counts cycles in RUN starting from 0.
  - When the count reaches TIMEOUT-1 and no verdict is produced that cycle, go to FAIL code 3.
  - A deciding store in the same cycle takes priority over the timeout.
- Latency: the verdict is registered. done/pass/fail_* become visible in the cycle after the deciding store's posedge.
- On FAIL 1/2: fail_addr/fail_data capture data_adr/write_data of that store.
- In PASS/FAIL, mem_write is ignored and the outputs hold.

Decomposition:
- Shared package store_check_pkg:
  - state_t enum {IDLE, RUN, PASS, FAIL}
  - fail_code_t enum {FC_NONE=0, FC_ADDR=1, FC_DATA=2, FC_TIMEOUT=3}
  - exp_entry_t struct {addr, data, mask}
- One sub-module, store_expect_table: DEPTH x exp_entry_t register file with synchronous write, combinational read, and synchronous clear on reset.

Test Plan:
- Legacy case: cfg entry0 {100, 25, FFFFFFFF}, num=1, window 96..96, arm. Stores (96,7), (100,25) -> pass=1, done=1, fail_code=0, store_cnt=2, one cycle after the second store.
- Data mismatch: same config, store (100,24) -> FAIL, fail_code=2, fail_addr=100, fail_data=24, pass=0.
- Unexpected address: same config, store (104,25) -> fail_code=1, fail_addr=104.
- Ordered three-entry sequence {(0x80,1),(0x84,2),(0x88,3)}, mask on entry1 = 0xFF:
  - Stores (0x80,1), (0x84,0x1202), (0x88,3) -> PASS, exp_ptr=3.
  - Re-arm and send (0x84,2) first -> fail_code=1.
- Watchdog: TIMEOUT=20, arm, no stores -> fail_code=3 exactly 20 cycles after entering RUN, with fail_addr=0. Repeat with the matching store on cycle 19 -> PASS, not timeout.
- Reset and control corners:
  - reset asserted mid-RUN -> all outputs 0 next cycle, table cleared.
  - cfg_we during RUN ignored.
  - arm with cfg_num=0 -> pass=1 one cycle later.

Source files
------------

// File: rtl/store_check_pkg.sv
// Shared types for the data-memory store sequence checker.
// Entries are fixed at SC_XLEN bits; the checker's XLEN must equal SC_XLEN.
package store_check_pkg;
   localparam int SC_XLEN = 32;

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_ADDR    = 2'd1,
      FC_DATA    = 2'd2,
      FC_TIMEOUT = 2'd3
   } fail_code_t;

   typedef struct packed {
      logic [SC_XLEN-1:0] addr;
      logic [SC_XLEN-1:0] data;
      logic [SC_XLEN-1:0] mask;
   } exp_entry_t;
endpackage

// File: rtl/store_expect_table.sv
// Expected-store register file: synchronous write, combinational read, cleared on reset.
module store_expect_table
   import store_check_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] widx,
   input  exp_entry_t               wentry,
   input  logic [$clog2(DEPTH)-1:0] ridx,
   output exp_entry_t               rentry
);
   exp_entry_t entries [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (we) begin
         entries[widx] <= wentry;
      end
   end

   assign rentry = entries[ridx];
endmodule

// File: rtl/store_sequence_checker.sv
// Monitors the core's store port against an ordered table of expected stores
// and produces a sticky registered verdict with failure code and captured store.
//
// state | meaning
// IDLE  | waiting for arm, table writable
// RUN   | matching stores against table[exp_ptr], watchdog running
// PASS  | all num_latched entries matched (sticky)
// FAIL  | address/data mismatch or watchdog expiry (sticky)
module store_sequence_checker
   import store_check_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 4,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_write,
   input  logic [XLEN-1:0]          data_adr,
   input  logic [XLEN-1:0]          write_data,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_idx,
   input  logic [XLEN-1:0]          cfg_addr,
   input  logic [XLEN-1:0]          cfg_data,
   input  logic [XLEN-1:0]          cfg_mask,
   input  logic [$clog2(DEPTH):0]   cfg_num,
   input  logic [XLEN-1:0]          ign_lo,
   input  logic [XLEN-1:0]          ign_hi,
   input  logic                     arm,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [1:0]               fail_code,
   output logic [XLEN-1:0]          fail_addr,
   output logic [XLEN-1:0]          fail_data,
   output logic [15:0]              store_cnt,
   output logic [$clog2(DEPTH):0]   exp_ptr
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   state_t           state;
   logic [PTR_W-1:0] num_latched;
   logic [XLEN-1:0]  win_lo, win_hi;
   logic [TO_W-1:0]  wd_cnt;
   exp_entry_t       cur;
   logic [PTR_W-1:0] ptr_nxt;
   logic             st_match, st_bad_data, st_bad_addr;

   store_expect_table #(.DEPTH(DEPTH)) u_table (
      .clk    (clk),
      .reset  (reset),
      .we     (cfg_we && (state != RUN)),
      .widx   (cfg_idx),
      .wentry ('{addr: cfg_addr, data: cfg_data, mask: cfg_mask}),
      .ridx   (exp_ptr[IDX_W-1:0]),
      .rentry (cur)
   );

   // Rule order: address hit decides match vs data fail; only then the scratch window.
   always_comb begin
      ptr_nxt     = exp_ptr + 1'b1;
      st_match    = 1'b0;
      st_bad_data = 1'b0;
      st_bad_addr = 1'b0;
      if (mem_write) begin
         if (data_adr == cur.addr) begin
            if (((write_data ^ cur.data) & cur.mask) == '0) st_match = 1'b1;
            else                                             st_bad_data = 1'b1;
         end else if (!((data_adr >= win_lo) && (data_adr <= win_hi))) begin
            st_bad_addr = 1'b1;
         end
      end
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         num_latched <= '0;
         win_lo      <= '0;
         win_hi      <= '0;
         wd_cnt      <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_code   <= FC_NONE;
         fail_addr   <= '0;
         fail_data   <= '0;
         store_cnt   <= '0;
         exp_ptr     <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mem_write && (store_cnt != 16'hFFFF)) store_cnt <= store_cnt + 16'd1;
               if (st_match) exp_ptr <= ptr_nxt;
               if (st_match && (ptr_nxt == num_latched)) begin
                  state <= PASS;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end else if (st_bad_data || st_bad_addr) begin
                  state     <= FAIL;
                  done      <= 1'b1;
                  fail_code <= st_bad_data ? FC_DATA : FC_ADDR;
                  fail_addr <= data_adr;
                  fail_data <= write_data;
               end else if (wd_cnt == '0) begin
                  state     <= FAIL;
                  done      <= 1'b1;
                  fail_code <= FC_TIMEOUT;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            default: begin
               if (arm) begin
                  num_latched <= cfg_num;
                  win_lo      <= ign_lo;
                  win_hi      <= ign_hi;
                  wd_cnt      <= TO_W'(TIMEOUT - 1);
                  fail_code   <= FC_NONE;
                  fail_addr   <= '0;
                  fail_data   <= '0;
                  store_cnt   <= '0;
                  exp_ptr     <= '0;
                  if (cfg_num == '0) begin
                     state <= PASS;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= RUN;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_store_sequence_checker.sv
// Directed bench for store_sequence_checker: vector table plus watchdog/reset corners.
module tb_store_sequence_checker;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic [31:0] data_adr, write_data;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_addr, cfg_data, cfg_mask;
   logic [2:0]  cfg_num;
   logic [31:0] ign_lo, ign_hi;
   logic        arm;
   logic        busy, done, pass;
   logic [1:0]  fail_code;
   logic [31:0] fail_addr, fail_data;
   logic [15:0] store_cnt;
   logic [2:0]  exp_ptr;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        arm;
      logic        mw;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        busy;
      logic        done;
      logic        pass;
      logic [1:0]  code;
      logic [31:0] fa;
      logic [31:0] fd;
      logic [15:0] cnt;
      logic [2:0]  ptr;
   } vec_t;

   vec_t vecs [24];

   store_sequence_checker #(.XLEN(32), .DEPTH(4), .TO_W(16), .TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
      .write_data(write_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_num(cfg_num), .ign_lo(ign_lo),
      .ign_hi(ign_hi), .arm(arm), .busy(busy), .done(done), .pass(pass),
      .fail_code(fail_code), .fail_addr(fail_addr), .fail_data(fail_data),
      .store_cnt(store_cnt), .exp_ptr(exp_ptr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic b, input logic d, input logic p,
                            input logic [1:0] c, input logic [31:0] fa, input logic [31:0] fd,
                            input logic [15:0] cnt, input logic [2:0] ptr);
      check({tag, " busy"}, 32'(busy), 32'(b));
      check({tag, " done"}, 32'(done), 32'(d));
      check({tag, " pass"}, 32'(pass), 32'(p));
      check({tag, " fail_code"}, 32'(fail_code), 32'(c));
      check({tag, " fail_addr"}, fail_addr, fa);
      check({tag, " fail_data"}, fail_data, fd);
      check({tag, " store_cnt"}, 32'(store_cnt), 32'(cnt));
      check({tag, " exp_ptr"}, 32'(exp_ptr), 32'(ptr));
   endtask

   task automatic cfg_entry(input logic [1:0] idx, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] m);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d; cfg_mask = m;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1; data_adr = a; write_data = d;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         arm = vecs[i].arm; mem_write = vecs[i].mw;
         data_adr = vecs[i].adr; write_data = vecs[i].dat;
         tick();
         arm = 1'b0; mem_write = 1'b0;
         check_all($sformatf("row%0d", i), vecs[i].busy, vecs[i].done, vecs[i].pass,
                   vecs[i].code, vecs[i].fa, vecs[i].fd, vecs[i].cnt, vecs[i].ptr);
      end
   endtask

   initial begin
      //           arm mw adr      dat        busy done pass code fa       fd         cnt ptr
      // single-entry legacy config {100,25,all-ones}, window 96..96
      vecs[0]  = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[1]  = '{0, 1, 96,      7,         1, 0, 0, 0, 0,       0,         1, 0};
      vecs[2]  = '{0, 1, 100,     25,        0, 1, 1, 0, 0,       0,         2, 1};
      vecs[3]  = '{0, 1, 5,       5,         0, 1, 1, 0, 0,       0,         2, 1};
      vecs[4]  = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[5]  = '{0, 1, 100,     24,        0, 1, 0, 2, 100,     24,        1, 0};
      vecs[6]  = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[7]  = '{0, 1, 104,     25,        0, 1, 0, 1, 104,     25,        1, 0};
      vecs[8]  = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[9]  = '{0, 0, 100,     25,        1, 0, 0, 0, 0,       0,         0, 0};
      vecs[10] = '{0, 1, 100,     25,        0, 1, 1, 0, 0,       0,         1, 1};
      // three-entry ordered sequence, entry1 masked to low byte
      vecs[11] = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[12] = '{0, 1, 'h80,    1,         1, 0, 0, 0, 0,       0,         1, 1};
      vecs[13] = '{0, 1, 'h84,    'h1202,    1, 0, 0, 0, 0,       0,         2, 2};
      vecs[14] = '{0, 1, 'h60,    'hdead,    1, 0, 0, 0, 0,       0,         3, 2};
      vecs[15] = '{0, 1, 'h88,    3,         0, 1, 1, 0, 0,       0,         4, 3};
      vecs[16] = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[17] = '{0, 1, 'h84,    2,         0, 1, 0, 1, 'h84,    2,         1, 0};
      vecs[18] = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[19] = '{0, 1, 'h80,    1,         1, 0, 0, 0, 0,       0,         1, 1};
      vecs[20] = '{0, 1, 'h84,    'h1203,    0, 1, 0, 2, 'h84,    'h1203,    2, 1};
      vecs[21] = '{1, 0, 0,       0,         1, 0, 0, 0, 0,       0,         0, 0};
      vecs[22] = '{0, 1, 'h80,    1,         1, 0, 0, 0, 0,       0,         1, 1};
      vecs[23] = '{0, 1, 'h88,    3,         0, 1, 0, 1, 'h88,    3,         2, 1};

      reset = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0;
      cfg_num = '0; ign_lo = '0; ign_hi = '0; arm = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

      cfg_entry(0, 100, 25, 32'hFFFF_FFFF);
      cfg_num = 1; ign_lo = 96; ign_hi = 96;
      run_vecs(0, 10);

      cfg_entry(0, 'h80, 1, 32'hFFFF_FFFF);
      cfg_entry(1, 'h84, 2, 32'h0000_00FF);
      cfg_entry(2, 'h88, 3, 32'hFFFF_FFFF);
      cfg_num = 3;
      run_vecs(11, 23);

      // watchdog: no stores, verdict exactly 20 cycles after entering RUN
      cfg_num = 1;
      do_arm();
      for (int k = 0; k < 19; k++) tick();
      check_all("wd_before", 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check_all("wd_expire", 0, 1, 0, 3, 0, 0, 0, 0);

      // matching store in the terminal watchdog cycle beats the timeout
      do_arm();
      for (int k = 0; k < 19; k++) tick();
      store('h80, 1);
      check_all("wd_store_wins", 0, 1, 1, 0, 0, 0, 1, 1);

      // cfg_we in RUN is ignored; reset mid-RUN clears outputs and table
      cfg_num = 3;
      do_arm();
      store('h80, 1);
      cfg_entry(1, 'h300, 9, 32'hFFFF_FFFF);
      store('h84, 2);
      check_all("cfg_in_run", 1, 0, 0, 0, 0, 0, 2, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all("reset_mid_run", 0, 0, 0, 0, 0, 0, 0, 0);
      cfg_num = 1;
      do_arm();
      store(0, 32'h1234);
      check_all("table_cleared", 0, 1, 1, 0, 0, 0, 1, 1);

      // arm with zero entries passes on the next cycle
      cfg_num = 0;
      do_arm();
      check_all("arm_num0", 0, 1, 1, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
